fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor of the EX-stage bypass selector.
- Keeps its own scoreboard of in-flight register writes across DEPTH post-issue pipeline slots (slot 0 = EX, 1 = MEM, 2 = WB, ...).
- Decides operand forwarding in ID and delivers registered selects to EX.
- Detects load-use hazards, raises stall, and inserts bubbles; honours global hold and flush.

Parameters:
- RA_W, 5, register address width
- DEPTH, 3, number of tracked slots (EX..WB); must be >= LOAD_SLOT+1
- LOAD_SLOT, 2, first slot index at which load data is forwardable
- SEL_W, $clog2(DEPTH), forward-select width (derived localparam)

Ports:
- clk, in, 1, clock, rising edge
- rst, in, 1, asynchronous active-high reset
- hold, in, 1, global freeze (e.g. memory wait); all state holds
- flush, in, 1, kill the ID instruction (branch redirect)
- id_valid, in, 1, ID holds a real instruction
- id_rs, in, RA_W, ID source A
- id_rt, in, RA_W, ID source B
- id_use_rs, in, 1, source A is actually read
- id_use_rt, in, 1, source B is actually read
- id_reg_write, in, 1, ID instruction writes the RF
- id_write_reg, in, RA_W, ID destination
- id_is_load, in, 1, ID instruction is a load (MemtoReg)
- stall, out, 1, hold PC/IF/ID and bubble EX (combinational)
- ex_fwd_a, out, SEL_W, EX source-A select: 0 = RF, k = slot-k result
- ex_fwd_b, out, SEL_W, EX source-B select, same encoding
- ex_valid, out, 1, EX slot holds a real instruction

Behaviour:
- Scoreboard entry per slot: {v, dst[RA_W], ld}.
- Reset (async, rst=1):
  - all entries v=0.
  - ex_fwd_a = ex_fwd_b = 0, ex_valid = 0.
  - stall is 0 because every v=0.
- Match rule: slot k matches source s iff v[k] && dst[k]==s && s!=0 && use_s && id_valid.
  - Only slots 0..DEPTH-2 are searched.
  - The slot DEPTH-1 producer writes the RF this cycle; the RF is write-before-read, so it needs no forwarding.
- Select: youngest matching slot k (smallest k) wins; next-cycle select = k+1. No match gives 0.
- Load-use: stall=1 iff the youngest match for either source has ld[k]=1 and k+1 < LOAD_SLOT.
  - With defaults, this is a load in EX followed immediately by a consumer in ID: 1 bubble.
  - With LOAD_SLOT=3, a consumer of a load still in EX gives 2 bubbles (k=0, then k=1).
- stall is forced 0 when flush=1 or id_valid=0. It is not gated by hold; during hold it is ignored by the pipeline.
- Clock edge update, priority hold > flush > stall > normal:
  - hold=1: everything keeps its value.
  - Otherwise the scoreboard shifts: slot[k+1] <= slot[k]; slot[DEPTH-1] is discarded.
  - slot0 <= {id_reg_write && id_write_reg!=0, id_write_reg, id_is_load} only when id_valid && !flush && !stall; otherwise slot0 <= bubble (v=0).
  - ex_valid <= id_valid && !flush && !stall.
  - ex_fwd_a/b <= the computed selects when an instruction issues; otherwise 0.
- The stalled ID instruction is re-evaluated the next cycle against the shifted scoreboard. Its selects then reflect the new slot positions (e.g. load now at slot 1 gives select 2).
- Simultaneous events:
  - flush plus stall: flush wins, no stall, bubble issued.
  - hold plus flush: hold wins, and flush must be re-presented after hold drops.
  - rst mid-stall: everything clears immediately, with no residual stall.
- Non-writing instructions (id_reg_write=0) still occupy slots as v=0 entries and advance normally.
- The register 0 destination is never recorded as valid.
- Latency: selects are valid in EX exactly 1 cycle after issue from ID.

Decomposition:
- Shared package (pipeline pkg):
  - RA_W.
  - slot index constants: SLOT_EX=0, SLOT_MEM=1, SLOT_WB=2.
  - FWD_RF=0 encoding.
  - the scoreboard entry struct {v, dst, ld}.
- One sub-module, fwd_match_sel: purely combinational priority search over DEPTH entries for one source, returning {hit, sel, is_ld_hit}. It is instantiated twice (rs, rt); the top holds the shift register and output registers.

Test Plan:
1. Back-to-back ALU: add $3 issued, then ID reads rs=$3 -> stall=0, next cycle ex_fwd_a=1, ex_fwd_b=0.
2. Distance-2 producer: write $5, an independent instruction, then a consumer with rt=$5 -> ex_fwd_b=2.
3. Youngest wins: two writes to $7 in consecutive slots -> select=1, not 2.
4. Load-use: lw $4 in EX, ID reads rs=$4 -> stall=1 for 1 cycle, ex_valid=0 on the bubble, then consumer issues with ex_fwd_a=2.
5. Register-zero and unused operands: producer writes $0, or id_use_rs=0 on a match -> select 0, stall 0.
6. Control priority:
   - hold=1 during load-use -> state frozen for N cycles, then resumes identically.
   - flush with stall -> stall=0, ex_valid=0.
   - rst pulse mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / hazard unit.
//   RA_W       : register address width used by the scoreboard entries
//   SLOT_*     : post-issue slot indices (EX, MEM, WB)
//   FWD_RF     : forward-select value meaning "use the register file"
//   sb_entry_t : one scoreboard entry {v, dst, ld}
package fwd_hazard_unit_pkg;

   localparam int RA_W     = 5;

   localparam int SLOT_EX  = 0;
   localparam int SLOT_MEM = 1;
   localparam int SLOT_WB  = 2;

   localparam int FWD_RF   = 0;

   typedef struct packed {
      logic            v;    // slot holds a valid register write
      logic [RA_W-1:0] dst;  // destination register
      logic            ld;   // producer is a load
   } sb_entry_t;

endpackage

// File: rtl/fwd_match_sel.sv
// Combinational priority search of the forwardable scoreboard slots for one
// source operand.
//   entries   : slots 0..DEPTH-2 (slot 0 = youngest)
//   src       : source register read in ID
//   use_src   : source is actually read
//   id_valid  : ID holds a real instruction
//   hit       : some searched slot produces src
//   sel       : k+1 for the youngest matching slot k, FWD_RF otherwise
//   is_ld_hit : the youngest matching slot is a load
module fwd_match_sel
   import fwd_hazard_unit_pkg::*;
#(
   parameter  int DEPTH = 3,
   localparam int SEL_W = $clog2(DEPTH)
) (
   input  sb_entry_t        entries [DEPTH-1],
   input  logic [RA_W-1:0]  src,
   input  logic             use_src,
   input  logic             id_valid,
   output logic             hit,
   output logic [SEL_W-1:0] sel,
   output logic             is_ld_hit
);

   always_comb begin
      hit       = 1'b0;
      sel       = SEL_W'(FWD_RF);
      is_ld_hit = 1'b0;
      if (id_valid && use_src && (src != '0)) begin
         // Walk oldest to youngest so the youngest match overwrites the rest.
         for (int unsigned i = 0; i < unsigned'(DEPTH - 1); i++) begin
            if (entries[DEPTH-2-i].v && (entries[DEPTH-2-i].dst == src)) begin
               hit       = 1'b1;
               sel       = SEL_W'(DEPTH - 1 - i);
               is_ld_hit = entries[DEPTH-2-i].ld;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks in-flight register writes over
// DEPTH post-issue slots, picks bypass sources for the ID instruction and
// delivers them registered to EX, stalling on load-use hazards.
//   clk, rst          : clock, asynchronous active-high reset
//   hold              : freeze all state
//   flush             : kill the ID instruction
//   id_*              : decoded ID instruction fields
//   stall             : hold PC/IF/ID and bubble EX (combinational)
//   ex_fwd_a/ex_fwd_b : EX operand selects, 0 = RF, k = slot-k result
//   ex_valid          : EX holds a real instruction
// RA_W must equal the package RA_W, which sizes the scoreboard entries.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter  int RA_W      = fwd_hazard_unit_pkg::RA_W,
   parameter  int DEPTH     = 3,
   parameter  int LOAD_SLOT = 2,
   localparam int SEL_W     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_reg_write,
   input  logic [RA_W-1:0]  id_write_reg,
   input  logic             id_is_load,
   output logic             stall,
   output logic [SEL_W-1:0] ex_fwd_a,
   output logic [SEL_W-1:0] ex_fwd_b,
   output logic             ex_valid
);

   sb_entry_t        sb     [DEPTH];
   sb_entry_t        search [DEPTH-1];
   sb_entry_t        new_entry;

   logic             hit_a, hit_b;
   logic             ld_a, ld_b;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic             issue;

   // The oldest slot writes the RF this cycle (write-before-read), so only
   // the younger slots take part in forwarding.
   always_comb begin
      for (int unsigned k = 0; k < unsigned'(DEPTH - 1); k++) begin
         search[k] = sb[k];
      end
   end

   fwd_match_sel #(.DEPTH(DEPTH)) u_match_rs (
      .entries   (search),
      .src       (id_rs),
      .use_src   (id_use_rs),
      .id_valid  (id_valid),
      .hit       (hit_a),
      .sel       (sel_a),
      .is_ld_hit (ld_a)
   );

   fwd_match_sel #(.DEPTH(DEPTH)) u_match_rt (
      .entries   (search),
      .src       (id_rt),
      .use_src   (id_use_rt),
      .id_valid  (id_valid),
      .hit       (hit_b),
      .sel       (sel_b),
      .is_ld_hit (ld_b)
   );

   // A load matched at slot k delivers data at select k+1; it is usable only
   // once that select reaches LOAD_SLOT.
   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush) begin
         stall = (hit_a && ld_a && (int'(sel_a) < LOAD_SLOT)) ||
                 (hit_b && ld_b && (int'(sel_b) < LOAD_SLOT));
      end
   end

   assign issue = id_valid && !flush && !stall;

   always_comb begin
      new_entry     = '0;
      new_entry.v   = id_reg_write && (id_write_reg != '0);
      new_entry.dst = id_write_reg;
      new_entry.ld  = id_is_load;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < unsigned'(DEPTH); k++) begin
            sb[k] <= '0;
         end
         ex_fwd_a <= '0;
         ex_fwd_b <= '0;
         ex_valid <= 1'b0;
      end else if (!hold) begin
         for (int unsigned k = 1; k < unsigned'(DEPTH); k++) begin
            sb[k] <= sb[k-1];
         end
         sb[SLOT_EX] <= issue ? new_entry : '0;
         ex_valid    <= issue;
         ex_fwd_a    <= issue ? sel_a : SEL_W'(FWD_RF);
         ex_fwd_b    <= issue ? sel_b : SEL_W'(FWD_RF);
      end
   end

endmodule
